// File: rtl/keypad_if.sv
// Key-event handshake between the keypad scanner and its consumer.
interface keypad_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 3x4 keypad scanner: one-hot column strobes, synchronized row sampling,
// whole-matrix debounce and a single key event per press over valid/ready.
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 3,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    keypad_if.master   key,
    output logic       key_down,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);
    localparam logic [3:0] StableMax  = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {StCol0, StCol1, StCol2, StEval} state_e;
    typedef enum logic [1:0] {ClsNone, ClsSingle, ClsMulti} cls_e;

    state_e     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] row_meta_q, row_sync_q;
    logic [3:0] sample_q [3];
    logic [3:0] sample_d [3];
    cls_e       prev_cls_q, prev_cls_d, cls;
    logic [3:0] prev_code_q, prev_code_d, code;
    logic [3:0] stable_q, stable_d, stable_next;
    logic [3:0] ones;
    logic [3:0] key_code_q, key_code_d;
    logic       armed_q, armed_d;
    logic       down_q, down_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    logic       last, is_eval, same, reached, key_event, accept, drop;

    function automatic logic [3:0] key_lut(input int r, input int c);
        if (r < 3) return 4'(3 * r + c + 1);
        case (c)
            0:       return 4'hA;
            1:       return 4'h0;
            default: return 4'hB;
        endcase
    endfunction

    // Scan sequencer
    always_comb begin
        state_d = state_q;
        settle_d = settle_q;
        col_out = 3'b000;
        is_eval = 1'b0;
        for (int c = 0; c < 3; c++) sample_d[c] = sample_q[c];
        last = (settle_q == SettleLast);
        if (state_q != StEval) settle_d = last ? 4'd0 : settle_q + 4'd1;
        unique case (state_q)
            StCol0: begin
                col_out = 3'b001;
                if (last) begin
                    sample_d[0] = row_sync_q;
                    state_d = StCol1;
                end
            end
            StCol1: begin
                col_out = 3'b010;
                if (last) begin
                    sample_d[1] = row_sync_q;
                    state_d = StCol2;
                end
            end
            StCol2: begin
                col_out = 3'b100;
                if (last) begin
                    sample_d[2] = row_sync_q;
                    state_d = StEval;
                end
            end
            StEval: begin
                is_eval = 1'b1;
                settle_d = 4'd0;
                state_d = StCol0;
            end
            default: state_d = StCol0;
        endcase
    end

    // Classify the 12 captured bits
    always_comb begin
        ones = 4'd0;
        code = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (sample_q[c][r]) begin
                    ones = ones + 4'd1;
                    code = key_lut(r, c);
                end
            end
        end
        if (ones == 4'd0) begin
            cls = ClsNone;
        end else if (ones == 4'd1) begin
            cls = ClsSingle;
        end else begin
            cls = ClsMulti;
            code = 4'd0;
        end
    end

    // Debounce and arming
    always_comb begin
        same = (cls == prev_cls_q) && (code == prev_code_q);
        if (!same) stable_next = 4'd1;
        else if (stable_q == StableMax) stable_next = StableMax;
        else stable_next = stable_q + 4'd1;
        reached = (stable_next == StableMax) && (stable_q != StableMax);
        key_event = is_eval && reached && (cls == ClsSingle) && armed_q;

        stable_d = stable_q;
        prev_cls_d = prev_cls_q;
        prev_code_d = prev_code_q;
        armed_d = armed_q;
        down_d = down_q;
        if (is_eval) begin
            stable_d = stable_next;
            prev_cls_d = cls;
            prev_code_d = code;
            if (key_event) armed_d = 1'b0;
            else if (cls == ClsNone && stable_next == StableMax) armed_d = 1'b1;
            if (reached) down_d = (cls == ClsSingle);
        end
    end

    // Event handshake; a same-cycle accept frees the slot for the new event
    always_comb begin
        accept = valid_q & key.key_ready;
        drop = key_event & valid_q & ~accept;
        valid_d = valid_q & ~accept;
        key_code_d = key_code_q;
        if (key_event && !drop) begin
            valid_d = 1'b1;
            key_code_d = code;
        end
        ovf_d = ovf_q;
        if (drop) ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCol0;
            settle_q    <= 4'd0;
            row_meta_q  <= 4'd0;
            row_sync_q  <= 4'd0;
            for (int c = 0; c < 3; c++) sample_q[c] <= 4'd0;
            prev_cls_q  <= ClsMulti;
            prev_code_q <= 4'd0;
            stable_q    <= 4'd0;
            armed_q     <= 1'b0;
            down_q      <= 1'b0;
            valid_q     <= 1'b0;
            key_code_q  <= 4'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            row_meta_q  <= row_in;
            row_sync_q  <= row_meta_q;
            for (int c = 0; c < 3; c++) sample_q[c] <= sample_d[c];
            prev_cls_q  <= prev_cls_d;
            prev_code_q <= prev_code_d;
            stable_q    <= stable_d;
            armed_q     <= armed_d;
            down_q      <= down_d;
            valid_q     <= valid_d;
            key_code_q  <= key_code_d;
            ovf_q       <= ovf_d;
        end
    end

    assign key.key_code  = key_code_q;
    assign key.key_valid = valid_q;
    assign key_down      = down_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a physical keypad model drives the rows,
// a scan-level reference model predicts events, a monitor checks accepted codes.
module tb_keypad_scan_ctrl;

    localparam int Settle = 3;
    localparam int Deb    = 4;
    localparam int Period = 3 * (Settle + 1) + 1;
    localparam logic [3:0] KeyCodes [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                              4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_in;
    logic [2:0] col_out;
    logic       key_down, overflow, ovf_clr;

    keypad_if kif ();

    keypad_scan_ctrl #(
        .SETTLE_CYCLES (Settle),
        .DEBOUNCE_SCANS(Deb)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .row_in  (row_in),
        .col_out (col_out),
        .key     (kif.master),
        .key_down(key_down),
        .overflow(overflow),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    // Pressed keys, bit index = row*3 + col; a row line reads high when a pressed
    // key in that row sits on the currently strobed column.
    logic [11:0] pressed;
    always_comb begin
        row_in = 4'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r * 3 + c] && col_out[c]) row_in[r] = 1'b1;
    end

    typedef struct {
        logic [11:0] set;
        int          scans;
        int          rmode;
    } seg_t;

    seg_t       segs[$];
    int         seg_left;
    int         ready_mode;
    int         ph;
    bit         m_valid, m_down, m_ovf, m_armed;
    logic [3:0] m_code;
    int         last_res, run;
    logic [3:0] exp_q[$];
    logic [3:0] exp_code;
    int         checks = 0;
    int         errors = 0;
    int         accepted = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int exp_col(input int p);
        int idx;
        idx = p / (Settle + 1);
        return (idx < 3) ? (1 << idx) : 0;
    endfunction

    task automatic model_reset();
        ph = 0;
        m_valid = 0;
        m_code = 4'd0;
        m_down = 0;
        m_ovf = 0;
        m_armed = 0;
        last_res = -2;
        run = 0;
    endtask

    task automatic load_seg();
        seg_t s;
        int   a, b;
        if (segs.size() > 0) begin
            s = segs.pop_front();
            pressed = s.set;
            seg_left = s.scans;
            ready_mode = s.rmode;
        end else begin
            a = $urandom_range(0, 99);
            pressed = 12'd0;
            if (a >= 40) pressed[$urandom_range(0, 11)] = 1'b1;
            if (a >= 88) begin
                a = $urandom_range(0, 11);
                b = (a + $urandom_range(1, 11)) % 12;
                pressed = 12'd0;
                pressed[a] = 1'b1;
                pressed[b] = 1'b1;
            end
            seg_left = $urandom_range(1, 6);
            ready_mode = ($urandom_range(0, 3) == 0) ? 4 : 0;
        end
    endtask

    // One clock: compare outputs, drive inputs, advance the model across the edge.
    task automatic step();
        int  n, res;
        bit  ev, drop, accept;
        check("col_out", col_out, exp_col(ph));
        check("key_valid", kif.key_valid, m_valid);
        check("key_code", kif.key_code, m_code);
        check("key_down", key_down, m_down);
        check("overflow", overflow, m_ovf);

        case (ready_mode)
            2:       kif.key_ready = 1'b1;
            0:       kif.key_ready = ($urandom_range(0, 3) != 0);
            default: kif.key_ready = 1'b0;
        endcase
        case (ready_mode)
            3:       ovf_clr = (ph == 6);
            0, 4:    ovf_clr = ($urandom_range(0, 31) == 0);
            default: ovf_clr = 1'b0;
        endcase

        accept = m_valid && kif.key_ready;
        ev = 0;
        drop = 0;
        res = -1;
        if (ph == Period - 1) begin
            n = $countones(pressed);
            if (n > 1) res = -2;
            else if (n == 1)
                for (int i = 0; i < 12; i++) if (pressed[i]) res = KeyCodes[i];
            run = (res == last_res) ? run + 1 : 1;
            last_res = res;
            ev = (run == Deb) && (res >= 0) && m_armed;
            if (ev) m_armed = 0;
            else if (res == -1 && run >= Deb) m_armed = 1;
            if (run == Deb) m_down = (res >= 0);
        end
        if (ev && m_valid && !accept) begin
            drop = 1;
            m_ovf = 1;
        end else if (ev) begin
            m_valid = 1;
            m_code = 4'(res);
            exp_q.push_back(4'(res));
        end else if (accept) begin
            m_valid = 0;
        end
        if (!drop && ovf_clr) m_ovf = 0;

        if (ph == Period - 1) begin
            seg_left--;
            if (seg_left <= 0) load_seg();
        end
        ph = (ph + 1) % Period;
        @(posedge clk);
        #2;
    endtask

    // Monitor: every accepted event must match the oldest predicted one.
    always @(negedge clk) begin
        if (rst_n && kif.key_valid && kif.key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_unexpected: got code %0d, none predicted", kif.key_code);
            end else begin
                exp_code = exp_q.pop_front();
                check("accept_code", kif.key_code, exp_code);
                accepted++;
            end
        end
    end

    initial begin
        // '#' through reset, release, re-press; bounce on '1'; '2'+'8' then '2';
        // '3' pending while '*' is dropped; clear, accept; '5' pending for reset.
        segs.push_back('{12'h800, 6, 2});
        segs.push_back('{12'h000, 5, 2});
        segs.push_back('{12'h800, 6, 2});
        segs.push_back('{12'h000, 5, 2});
        for (int i = 0; i < 3; i++) begin
            segs.push_back('{12'h001, 1, 2});
            segs.push_back('{12'h000, 1, 2});
        end
        segs.push_back('{12'h001, 6, 2});
        segs.push_back('{12'h000, 5, 2});
        segs.push_back('{12'h082, 6, 2});
        segs.push_back('{12'h002, 6, 2});
        segs.push_back('{12'h000, 5, 2});
        segs.push_back('{12'h004, 6, 1});
        segs.push_back('{12'h000, 5, 1});
        segs.push_back('{12'h200, 6, 1});
        segs.push_back('{12'h000, 2, 3});
        segs.push_back('{12'h000, 3, 2});
        segs.push_back('{12'h000, 5, 2});
        segs.push_back('{12'h010, 8, 1});

        load_seg();
        rst_n = 1'b0;
        kif.key_ready = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 20000; i++) begin
            if (segs.size() == 0 && seg_left <= 3 && ph == 5) break;
            step();
        end
        if (!(segs.size() == 0 && seg_left <= 3 && ph == 5)) begin
            checks++;
            errors++;
            $display("FAIL reset_setup: never reached COL1 with pending '5' event");
        end
        check("pre_reset_valid", kif.key_valid, 1);
        check("pre_reset_code", kif.key_code, 5);

        #1;
        rst_n = 1'b0;
        #1;
        check("rst_col_out", col_out, 1);
        check("rst_key_valid", kif.key_valid, 0);
        check("rst_key_code", kif.key_code, 0);
        check("rst_key_down", key_down, 0);
        check("rst_overflow", overflow, 0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 300 * Period; i++) step();

        segs.push_back('{12'h000, 8, 2});
        for (int i = 0; i < 16 * Period; i++) step();

        check("queue_drained", exp_q.size(), 0);
        check("events_accepted", (accepted >= 6) ? 1 : 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequencer for the 3-column × 4-row membrane keypad on the safe's uio pins. It drives one-hot column strobes, samples the row lines through a synchronizer, debounces whole-matrix scans and emits one 4-bit key event per press over a valid/ready handshake. It replaces free-running scanning on a divided clock and feeds the safe controller directly from the main clock domain.

## Interface
Parameters:
- SETTLE_CYCLES, 3: cycles a column is driven before its rows are sampled; legal range 2..15 (covers the 2-flop synchronizer).
- DEBOUNCE_SCANS, 4: consecutive identical scan results required to accept a press or release; legal range 2..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- row_in  in  4  raw row lines, active-high, asynchronous to clk.
- col_out  out  3  one-hot column strobe, active-high.
- key_code  out  4  code of the accepted key; stable while key_valid=1.
- key_valid  out  1  event pending.
- key_ready  in  1  consumer accepts event when key_valid & key_ready.
- key_down  out  1  debounced level: a single key is currently held.
- overflow  out  1  sticky: an event was dropped while one was pending.
- ovf_clr  in  1  synchronous clear of overflow.

## Operation
- row_in passes through a 2-flop synchronizer; only synchronized rows are used.
- FSM states: COL0, COL1, COL2, EVAL. Reset state COL0 with settle counter 0.
- COLc: col_out = one-hot bit c; lasts SETTLE_CYCLES+1 cycles; on the last cycle the 4 synchronized rows are captured into sample[c]. COL0→COL1→COL2→EVAL.
- EVAL: col_out = 3'b000 for one cycle; classify the 12 sample bits, then → COL0.
  - Zero bits set: NONE.
  - Exactly one bit set at row r, col c: SINGLE. Rows 0-2 give code 3r+c+1 (1..9). Row 3 gives col0 = 4'hA (*), col1 = 4'h0, col2 = 4'hB (#).
  - Two or more bits set: MULTI. A MULTI result is never accepted as a key.
- Debounce: the result tuple {class, code} is compared with the previous EVAL's tuple. If equal, stable_cnt increments and saturates at DEBOUNCE_SCANS; otherwise stable_cnt = 1. The previous tuple resets to MULTI.
- armed flag:
  - Resets to 0, so a key held through reset produces no event.
  - Set when NONE reaches stable_cnt = DEBOUNCE_SCANS.
  - Cleared when an event is generated.
- Event: in EVAL, when SINGLE reaches stable_cnt = DEBOUNCE_SCANS (the transition into that value only) and armed = 1, generate an event with the code.
- key_down = 1 while the last accepted stable result is SINGLE. It is cleared when NONE or MULTI becomes stable.
- Handshake:
  - Event with key_valid = 0: key_code is loaded and key_valid = 1.
  - Event with key_valid = 1: the event is dropped, key_code is unchanged and overflow = 1.
  - key_valid & key_ready clears key_valid at the next edge.
  - If an event occurs in the same cycle as the accept, the new event is loaded, key_valid stays 1, and no overflow is raised.
- overflow clears on ovf_clr = 1 unless a drop occurs in the same cycle; the drop wins.

## Timing
- Reset values: col_out = 3'b001, key_code = 0, key_valid = 0, key_down = 0, overflow = 0, stable_cnt = 0, armed = 0, synchronizer = 0.
- Scan period = 3·(SETTLE_CYCLES+1)+1 cycles; 13 with defaults.
- key_valid and key_down rise on the edge ending the qualifying EVAL cycle.
- Minimum press-to-valid latency = DEBOUNCE_SCANS scan periods, plus up to one partial scan.
- Accept-to-clear: 1 cycle. key_valid may stay high indefinitely; scanning never stalls.
- rst_n low mid-scan: all state returns to reset values immediately, with no wait for a clock edge. The first scan after release starts at COL0.

## Test plan
- Reset with no key, then 4 idle scans, then hold row1 when col1 = 1 (key "5"). Required: key_valid = 1 and key_code = 5 after the EVAL of the 4th matching scan; key_down = 1; col_out sequence 001×4, 010×4, 100×4, 000×1.
- Key "#" (row3/col2) held through reset, then released for 4 scans, then pressed again. Required: no event before the release; exactly one event with code 4'hB after the second press.
- Bounce: toggle row0/col0 every scan for 6 scans, then hold it. Required: no event until 4 stable scans have been seen, then exactly one event with code 1.
- Two keys ("2" and "8") held together. Required: no event and key_down = 0. Release "8": a code 2 event follows 4 scans later, but only if the armed condition was met beforehand.
- Press "3", keep key_ready = 0, release, press "*". Required: key_code stays 3 and overflow = 1. Pulse ovf_clr: overflow = 0. Accept with key_ready = 1: key_valid = 0 one cycle later.
- Assert rst_n = 0 mid-COL1 while key_valid = 1. Required: all outputs at reset values asynchronously, and col_out = 001 on the first edge after rst_n rises.
